// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and FSM encoding for the main memory controller
// and the cache models that talk to it.
//   BLOCK_W  : width of one cache block (four 32-bit words, word 0 in MSBs)
//   WORD_W   : width of one word
//   ADDR_W   : byte address width
//   OFFSET_W : byte-within-block offset bits (ignored by the memory)
//   CNT_W    : latency counter width
package mem_pkg;
    localparam int BLOCK_W  = 128;
    localparam int WORD_W   = 32;
    localparam int ADDR_W   = 10;
    localparam int OFFSET_W = 4;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;
endpackage

// File: rtl/mem_block_array.sv
// mem_block_array: NUM_BLOCKS x BLOCK_W block storage.
//   clk, rst : clock, asynchronous active-high clear of every entry
//   we       : write enable, data committed on the rising edge
//   waddr    : block index written
//   wdata    : block written
//   raddr    : block index read (combinational read)
//   rdata    : block at raddr
module mem_block_array
    import mem_pkg::*;
#(
    parameter int NUM_BLOCKS = 64,
    parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr,
    output logic [BLOCK_W-1:0] rdata
);
    logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] mem_q;
    logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: fixed-latency block memory serving one request at a time.
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : cache presents a block request
//   req_write   : 1 = block write, 0 = block read
//   req_addr    : byte address; block index = req_addr[9:4]
//   req_wdata   : write block (word 0 in [127:96])
//   req_ready   : request accepted this cycle when req_valid is also high
//   resp_valid  : one-cycle completion pulse
//   resp_rdata  : last read block; held across write responses
//   busy        : a request is outstanding
// Accept edge to resp_valid-raising edge is LATENCY edges.
module main_memory_ctrl
    import mem_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int NUM_BLOCKS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [BLOCK_W-1:0] req_wdata,
    output logic               req_ready,
    output logic               resp_valid,
    output logic [BLOCK_W-1:0] resp_rdata,
    output logic               busy
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    mem_state_e          state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                wr_q,         wr_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [BLOCK_W-1:0]  wdata_q,      wdata_d;
    logic [BLOCK_W-1:0]  rdata_q,      rdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic                busy_q,       busy_d;

    logic                arr_we;
    logic [BLOCK_W-1:0]  arr_rdata;
    logic                unused_addr_bits;

    // Byte offset within a block carries no meaning for block transfers.
    assign unused_addr_bits = ^req_addr[OFFSET_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        arr_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    idx_d   = req_addr[OFFSET_W +: IDX_W];
                    wdata_d = req_wdata;
                    cnt_d   = LAT_M1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    // Read sample and write commit both land on the RESP entry edge.
                    state_d = ST_RESP;
                    if (wr_q) begin
                        arr_we = 1'b1;
                    end else begin
                        rdata_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    mem_block_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_q),
        .rdata (arr_rdata)
    );

    // Gated by rst so the cache never sees ready while reset is held.
    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Bench for main_memory_ctrl: three builds (LATENCY 4, 1, 15) driven with
// directed and random block traffic, checked against a per-build block array
// model and the LATENCY-edge response timing rule.
module tb_main_memory_ctrl;
    localparam int NDUT = 3;

    logic         clk;
    logic         rst;
    logic         req_valid  [NDUT];
    logic         req_write  [NDUT];
    logic [9:0]   req_addr   [NDUT];
    logic [127:0] req_wdata  [NDUT];
    logic         req_ready  [NDUT];
    logic         resp_valid [NDUT];
    logic [127:0] resp_rdata [NDUT];
    logic         busy       [NDUT];

    int n_tests;
    int n_fail;

    logic [127:0] mdl     [NDUT][64];
    logic [127:0] last_rd [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        main_memory_ctrl #(
            .LATENCY    (g == 0 ? 4 : (g == 1 ? 1 : 15)),
            .NUM_BLOCKS (64)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int d = 0; d < NDUT; d++) begin
            last_rd[d] = '0;
            for (int b = 0; b < 64; b++) mdl[d][b] = '0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first IDLE cycle after RESP so the next call is back-to-back.
    task automatic txn(input int d, input bit wr, input logic [9:0] addr,
                       input logic [127:0] data, input bit noise);
        int lat, first, pulses, idx;
        logic [127:0] exp_rd;
        lat    = lat_of(d);
        idx    = int'(addr[9:4]);
        exp_rd = wr ? last_rd[d] : mdl[d][idx];
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = data;
        #1;
        chk($sformatf("d%0d ready_at_issue", d), 128'(req_ready[d]), 128'd1);
        @(posedge clk);
        first  = -1;
        pulses = 0;
        for (int i = 0; i <= lat + 1; i++) begin
            @(negedge clk);
            if (resp_valid[d]) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i == 0) begin
                chk($sformatf("d%0d busy_after_accept", d), 128'(busy[d]), 128'd1);
                chk($sformatf("d%0d ready_low_busy", d), 128'(req_ready[d]), 128'd0);
            end
            if (i == lat) begin
                chk($sformatf("d%0d busy_in_resp", d), 128'(busy[d]), 128'd1);
                chk($sformatf("d%0d rdata_at_resp", d), resp_rdata[d], exp_rd);
            end
            if (i == lat + 1) begin
                chk($sformatf("d%0d busy_idle", d), 128'(busy[d]), 128'd0);
                chk($sformatf("d%0d ready_idle", d), 128'(req_ready[d]), 128'd1);
                chk($sformatf("d%0d rdata_held", d), resp_rdata[d], exp_rd);
            end
            if (noise && i < lat) begin
                req_valid[d] = 1'b1;
                req_write[d] = 1'($urandom);
                req_addr[d]  = 10'($urandom);
                req_wdata[d] = rnd_block();
            end else begin
                req_valid[d] = 1'b0;
            end
        end
        chk($sformatf("d%0d latency", d), 128'(first), 128'(lat));
        chk($sformatf("d%0d pulses", d), 128'(pulses), 128'd1);
        if (wr) mdl[d][idx] = data;
        else    last_rd[d] = exp_rd;
    endtask

    initial begin
        int pulses;
        logic [127:0] blk;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
        end
        model_clear();
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("d%0d rst_ready", d), 128'(req_ready[d]), 128'd0);
            chk($sformatf("d%0d rst_resp_valid", d), 128'(resp_valid[d]), 128'd0);
            chk($sformatf("d%0d rst_busy", d), 128'(busy[d]), 128'd0);
            chk($sformatf("d%0d rst_rdata", d), resp_rdata[d], 128'd0);
        end
        rst = 1'b0;

        // Directed traffic on every build, issued back to back.
        blk = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int d = 0; d < NDUT; d++) begin
            txn(d, 1'b0, 10'h3F0, rnd_block(), 1'b0);
            txn(d, 1'b1, 10'h040, blk, 1'b0);
            txn(d, 1'b0, 10'h04C, rnd_block(), 1'b0);
            txn(d, 1'b1, 10'h080, rnd_block(), 1'b1);
            txn(d, 1'b0, 10'h085, rnd_block(), 1'b1);
        end

        // Random traffic concentrated on a few blocks so reads hit writes.
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 40; k++) begin
                logic [9:0] a;
                a = {($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7)),
                     4'($urandom)};
                txn(d, 1'($urandom), a, rnd_block(), ($urandom_range(0, 4) == 0));
            end
        end

        // Reset during WAIT of a write: abort, no response, array cleared.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 10'h100;
        req_wdata[0] = rnd_block();
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst busy", 128'(busy[0]), 128'd0);
        chk("midrst ready", 128'(req_ready[0]), 128'd0);
        chk("midrst resp_valid", 128'(resp_valid[0]), 128'd0);
        chk("midrst rdata", resp_rdata[0], 128'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        pulses = 0;
        for (int i = 0; i < lat_of(0) + 3; i++) begin
            @(negedge clk);
            if (resp_valid[0]) pulses++;
        end
        chk("midrst no_resp", 128'(pulses), 128'd0);
        txn(0, 1'b0, 10'h100, rnd_block(), 1'b0);
        txn(0, 1'b0, 10'h040, rnd_block(), 1'b0);
        txn(2, 1'b0, 10'h04C, rnd_block(), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/main_memory_ctrl.md
MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request accept to response (legal range 1..15).
REQ-002 SHALL have parameter NUM_BLOCKS, default 64, meaning 128-bit blocks stored (1024 bytes total).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  cache presents a block request.
REQ-006 SHALL have port req_write  input  1  1 = block write, 0 = block read.
REQ-007 SHALL have port req_addr  input  10  byte address; block index = req_addr[9:4], bits [3:0] ignored.
REQ-008 SHALL have port req_wdata  input  128  write block; word 0 in [127:96], word 3 in [31:0].
REQ-009 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-010 SHALL have port resp_valid  output  1  one-cycle pulse marking completion.
REQ-011 SHALL have port resp_rdata  output  128  read block, same word order as req_wdata.
REQ-012 SHALL have port busy  output  1  high while a request is outstanding.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
REQ-015 On accept: SHALL latch req_write, block index, req_wdata; load latency counter with LATENCY-1; go to WAIT.
REQ-016 In WAIT: SHALL decrement the counter each cycle; when the counter is 0, go to RESP on the next edge.
REQ-017 On entering RESP: read returns stored block on resp_rdata; write commits latched data to the array on that same edge.
REQ-018 SHALL hold resp_valid high for exactly the one cycle spent in RESP, then return to IDLE.
REQ-019 Accept-to-resp_valid SHALL be exactly LATENCY+1 cycles (accept edge to edge raising resp_valid = LATENCY edges, inclusive of WAIT exit).
REQ-020 SHALL keep resp_rdata stable after a read until the next read response; write responses SHALL NOT alter resp_rdata.
REQ-021 SHALL assert busy in WAIT and RESP, deassert in IDLE.
REQ-022 SHALL ignore req_valid and input changes while not in IDLE; only one outstanding request.
REQ-023 SHALL give back-to-back requests no bubble beyond RESP: a new request is acceptable in the IDLE cycle following RESP.
REQ-024 Read after write to the same block SHALL return the written data.
REQ-025 Counter width SHALL be 4 bits; LATENCY=1 SHALL skip WAIT counting and go WAIT->RESP after one cycle.

Reset
REQ-026 Reset assertion SHALL immediately force IDLE, req_ready=0 while rst high, resp_valid=0, busy=0, resp_rdata=0, counter=0.
REQ-027 Reset SHALL clear all NUM_BLOCKS array entries to zero.
REQ-028 Reset mid-operation SHALL abort the request; a pending write SHALL NOT be committed; no response pulse SHALL follow.

Structure
REQ-029 SHALL place block width (128), word width (32), address width (10), and FSM state encoding in shared package mem_pkg, also used by the cache models.
REQ-030 SHALL contain one sub-module, mem_block_array (NUM_BLOCKS x 128 storage, sync write, async read, async clear); the FSM stays in main_memory_ctrl.

Verification
REQ-031 Reset then read addr 0x3F0 -> after LATENCY+1 cycles resp_valid pulse, resp_rdata=128'h0.
REQ-032 Write addr 0x040 data {32'h11111111,32'h22222222,32'h33333333,32'h44444444}, then read 0x04C -> identical 128-bit block returned.
REQ-033 Hold req_valid high during WAIT with different addr -> ignored; req_ready=0, busy=1 until after RESP; one response only.
REQ-034 Assert rst during WAIT of write to 0x100 -> immediate IDLE, no resp_valid; subsequent read of 0x100 returns 0.
REQ-035 LATENCY=1 and LATENCY=15 builds -> resp_valid exactly 2 and 16 cycles after accept; back-to-back reads accepted in cycle after each RESP.
